// File: rtl/fround_pkg.sv
// fround_pkg: shared types and constants for the pipelined binary32 rounding unit.
//   rmode_e : per-operand rounding mode (floor, ceil, trunc, round-to-nearest-even)
//   stage_t : payload carried from the decode cut to the increment cut
package fround_pkg;

  typedef enum logic [1:0] {
    RM_FLOOR = 2'd0,
    RM_CEIL  = 2'd1,
    RM_TRUNC = 2'd2,
    RM_RNE   = 2'd3
  } rmode_e;

  localparam logic [7:0]  BIAS       = 8'd127;
  localparam int          MANT_W     = 23;
  // Smallest exponent at which every binary32 value is already an integer.
  localparam logic [7:0]  EXP_INT    = 8'd150;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;

  // imant is the stored mantissa of the integer part (hidden bit implied),
  // half is 1<<(k-1) where k is the number of fraction bits, and lsb is the
  // integer-part bit of weight 1 (used for the round-to-even tie break).
  typedef struct packed {
    logic              sign;
    logic [7:0]        expo;
    logic [MANT_W-1:0] imant;
    logic [MANT_W-1:0] frac;
    logic [MANT_W-1:0] half;
    logic              lsb;
    rmode_e            mode;
    logic [31:0]       spec_res;
    logic              spec_inx;
    logic              special;
  } stage_t;

endpackage

// File: rtl/fround_core.sv
// fround_core: combinational halves of the rounding datapath.
//   x, mode      -> dec          : stage-1 decode (field split, fraction mask,
//                                  all cases that need no increment resolved)
//   fin_in       -> y, inexact   : stage-2 increment and renormalise
// The two halves are independent; the pipe decides where registers sit.
module fround_core
  import fround_pkg::*;
(
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  output stage_t      dec,
  input  stage_t      fin_in,
  output logic [31:0] y,
  output logic        inexact
);

  logic              s;
  logic [7:0]        e;
  logic [MANT_W-1:0] m;

  assign s = x[31];
  assign e = x[30:23];
  assign m = x[22:0];

  // ---------------------------------------------------------------- decode
  logic [7:0]        sh;
  logic [MANT_W-1:0] mask;
  logic [MANT_W-1:0] half;

  always_comb begin
    dec  = '0;
    // sh = e - 127 is the count of integer bits below the hidden bit; it is
    // only meaningful for 127..149, the other exponents never use the mask.
    sh   = e - BIAS;
    mask = 23'h7F_FFFF >> sh;
    half = mask ^ (mask >> 1);

    dec.sign  = s;
    dec.expo  = e;
    dec.mode  = rmode_e'(mode);
    dec.frac  = m & mask;
    dec.half  = half;
    dec.imant = m & ~mask;
    dec.lsb   = |({1'b1, m} & {half, 1'b0});

    if (e == 8'hFF) begin
      // Inf passes through; NaN comes back quieted.
      dec.special  = 1'b1;
      dec.spec_res = (m != '0) ? (x | 32'h0040_0000) : x;
    end else if (e >= EXP_INT) begin
      dec.special  = 1'b1;
      dec.spec_res = x;
    end else if (e == 8'd0) begin
      dec.special  = 1'b1;
      dec.spec_res = {s, 31'd0};
    end else if (e < BIAS) begin
      // 0 < |x| < 1: result is a signed zero or a signed one.
      dec.special  = 1'b1;
      dec.spec_inx = 1'b1;
      case (rmode_e'(mode))
        RM_FLOOR: dec.spec_res = s ? FP_NEG_ONE : 32'h0000_0000;
        RM_CEIL:  dec.spec_res = s ? 32'h8000_0000 : FP_ONE;
        RM_TRUNC: dec.spec_res = {s, 31'd0};
        default:  dec.spec_res = (e == 8'd126 && m != '0) ?
                                 (s ? FP_NEG_ONE : FP_ONE) : {s, 31'd0};
      endcase
    end
  end

  // ------------------------------------------------------------- increment
  logic        inc;
  logic        frac_nz;
  logic [23:0] sum;

  always_comb begin
    frac_nz = (fin_in.frac != '0);
    case (fin_in.mode)
      RM_FLOOR: inc = fin_in.sign && frac_nz;
      RM_CEIL:  inc = !fin_in.sign && frac_nz;
      RM_TRUNC: inc = 1'b0;
      default:  inc = (fin_in.frac > fin_in.half) ||
                      ((fin_in.frac == fin_in.half) && fin_in.lsb);
    endcase

    // Adding 1<<k to the stored mantissa: bit 23 of the sum is the carry out
    // of the hidden bit, in which case the low bits are necessarily zero.
    sum = {1'b0, fin_in.imant} + (inc ? {fin_in.half, 1'b0} : 24'd0);

    if (fin_in.special) begin
      y       = fin_in.spec_res;
      inexact = fin_in.spec_inx;
    end else if (sum[23]) begin
      y       = {fin_in.sign, fin_in.expo + 8'd1, 23'd0};
      inexact = frac_nz;
    end else begin
      y       = {fin_in.sign, fin_in.expo, sum[22:0]};
      inexact = frac_nz;
    end
  end

endmodule

// File: rtl/fround_pipe.sv
// fround_pipe: NSTAGE-deep pipelined binary32 floor/ceil/trunc/RNE unit.
//   clk, rstn           : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (x, mode)
//   out_valid, out_ready: result handshake (y, inexact)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high with rstn = 1. The whole pipe advances together when !out_valid ||
// out_ready; in_ready is exactly that condition (gated by rstn), so it is
// combinational from out_ready. Bubbles are kept while stalled.
// Register placement: NSTAGE=1 puts decode and increment in one stage;
// NSTAGE>=2 registers the decoded payload, then the result, then NSTAGE-2
// plain retiming registers on the result.
module fround_pipe
  import fround_pkg::*;
#(
  parameter int NSTAGE = 2
)(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        inexact
);

  localparam int NR = (NSTAGE > 1) ? NSTAGE - 1 : 1;

  logic              advance;
  logic [NSTAGE-1:0] v_q;
  logic [32:0]       r_q [NR];
  stage_t            dec;
  stage_t            fin_in;
  logic [31:0]       fin_y;
  logic              fin_inx;

  assign out_valid = v_q[NSTAGE-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = rstn && advance;
  assign y         = r_q[NR-1][32:1];
  assign inexact   = r_q[NR-1][0];

  fround_core u_core (
    .x       (x),
    .mode    (mode),
    .dec     (dec),
    .fin_in  (fin_in),
    .y       (fin_y),
    .inexact (fin_inx)
  );

  generate
    if (NSTAGE == 1) begin : g_one
      assign fin_in = dec;
      always_ff @(posedge clk) begin
        if (!rstn) begin
          v_q    <= '0;
          r_q[0] <= '0;
        end else if (advance) begin
          v_q    <= in_valid;
          r_q[0] <= {fin_y, fin_inx};
        end
      end
    end else begin : g_multi
      stage_t p_q;
      assign fin_in = p_q;
      always_ff @(posedge clk) begin
        if (!rstn) begin
          v_q <= '0;
          p_q <= '0;
          for (int i = 0; i < NR; i++) r_q[i] <= '0;
        end else if (advance) begin
          v_q    <= {v_q[NSTAGE-2:0], in_valid};
          p_q    <= dec;
          r_q[0] <= {fin_y, fin_inx};
          for (int i = 1; i < NR; i++) r_q[i] <= r_q[i-1];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fround_pipe.sv
// tb_fround_pipe: randomized and directed bench for fround_pipe (NSTAGE=3).
// Expected results come from an integer-arithmetic rounding model; a negedge
// monitor scores every output transfer, latency, stall hold and in_ready.
module tb_fround_pipe;

  localparam int NSTAGE = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        inexact;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit rnd_rdy = 0;

  logic [32:0] exp_q[$];
  int          acc_cyc_q[$];
  int          acc_stall_q[$];

  fround_pipe #(.NSTAGE(NSTAGE)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .inexact   (inexact)
  );

  // ------------------------------------------------------ clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------- checker
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h at cyc %0d", name, act, req, cyc);
    end
  endtask

  // ----------------------------------------------------- reference model
  // Rounds |x| as the integer mantissa scaled by 2^-k, then re-encodes the
  // integer result. Returns {y, inexact}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [1:0] md);
    int          e;
    longint      mg, q, rem, k, mag;
    int          cmp;
    bit          up;
    int          p;
    logic [31:0] r;
    logic [22:0] mb;
    e = int'(a[30:23]);
    if (e == 255) return {(a[22:0] != 0) ? (a | 32'h0040_0000) : a, 1'b0};
    if (e >= 150) return {a, 1'b0};
    if (e == 0) return {a[31], 31'd0, 1'b0};
    mg = longint'({1'b1, a[22:0]});
    k  = longint'(150 - e);
    if (k > 40) begin
      q = 0; rem = mg; cmp = -1;
    end else begin
      q   = mg >> k;
      rem = mg - (q << k);
      if (2 * rem > (longint'(1) << k)) cmp = 1;
      else if (2 * rem == (longint'(1) << k)) cmp = 0;
      else cmp = -1;
    end
    case (md)
      2'd0:    up = a[31] && (rem != 0);
      2'd1:    up = !a[31] && (rem != 0);
      2'd2:    up = 1'b0;
      default: up = (cmp > 0) || (cmp == 0 && q[0]);
    endcase
    mag = q + (up ? 1 : 0);
    if (mag == 0) begin
      r = {a[31], 31'd0};
    end else begin
      p = 0;
      for (int i = 0; i < 26; i++) if (mag[i]) p = i;
      mb = 23'((mag << (23 - p)) & 64'h7F_FFFF);
      r  = {a[31], 8'(127 + p), mb};
    end
    return {r, rem != 0};
  endfunction

  task automatic pin(input logic [31:0] a, input logic [1:0] md,
                     input logic [31:0] ry, input logic rinx);
    logic [32:0] m;
    m = model(a, md);
    chk("model_y", m[32:1], ry);
    chk("model_inexact", {31'd0, m[0]}, {31'd0, rinx});
  endtask

  // ---------------------------------------------------------------- monitor
  bit          prev_stall = 0;
  bit          rst_seen = 0;
  logic [32:0] prev_out = '0;

  always @(negedge clk) begin
    logic [32:0] e;
    int          ac, as;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rstn && (!out_valid || out_ready)});
    if (!rstn) begin
      exp_q.delete();
      acc_cyc_q.delete();
      acc_stall_q.delete();
      prev_stall = 0;
      rst_seen   = 1;
    end else begin
      if (rst_seen) begin
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_y", y, 32'd0);
        chk("reset_inexact", {31'd0, inexact}, 32'd0);
        rst_seen = 0;
      end
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_y", y, prev_out[32:1]);
        chk("hold_inexact", {31'd0, inexact}, {31'd0, prev_out[0]});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", y, 32'hxxxx_xxxx);
        end else begin
          e  = exp_q.pop_front();
          ac = acc_cyc_q.pop_front();
          as = acc_stall_q.pop_front();
          chk("result_y", y, e[32:1]);
          chk("result_inexact", {31'd0, inexact}, {31'd0, e[0]});
          chk("latency", cyc - ac, NSTAGE + (stall_cnt - as));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(x, mode));
        acc_cyc_q.push_back(cyc);
        acc_stall_q.push_back(stall_cnt);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {y, inexact};
      if (prev_stall) stall_cnt++;
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] a, input logic [1:0] md);
    int n;
    bit ok;
    n = 0;
    in_valid = 1'b1;
    x        = a;
    mode     = md;
    do begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 500);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] rand_op();
    int          sel, t;
    logic [7:0]  e;
    logic [22:0] m;
    sel = $urandom_range(0, 9);
    if (sel < 6)       e = 8'($urandom_range(118, 152));
    else if (sel == 6) e = 8'd255;
    else if (sel == 7) e = 8'd0;
    else               e = 8'($urandom_range(0, 255));
    m = 23'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      // Leave a single set bit below a random cut to hit exact ties.
      t = $urandom_range(0, 22);
      m = (m & ~((23'd1 << (t + 1)) - 23'd1)) | (23'd1 << t);
    end
    return {1'($urandom), e, m};
  endfunction

  // --------------------------------------------------------------- stimulus
  logic [31:0] dir_x [14] = '{32'hC020_0000, 32'h3E99_999A, 32'hBE99_999A, 32'hBE99_999A,
                              32'h4020_0000, 32'h4060_0000, 32'h3F00_0000, 32'h3FFF_FFFF,
                              32'h4B80_0000, 32'h7FA0_0000, 32'h8000_0001, 32'hBE99_999A,
                              32'h7F80_0000, 32'hBF40_0000};
  logic [1:0]  dir_m [14] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1,
                              2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3};

  initial begin
    // Hand-computed pins for the model.
    pin(32'hC020_0000, 2'd0, 32'hC040_0000, 1'b1);
    pin(32'h3E99_999A, 2'd1, 32'h3F80_0000, 1'b1);
    pin(32'hBE99_999A, 2'd0, 32'hBF80_0000, 1'b1);
    pin(32'hBE99_999A, 2'd2, 32'h8000_0000, 1'b1);
    pin(32'h4020_0000, 2'd3, 32'h4000_0000, 1'b1);
    pin(32'h4060_0000, 2'd3, 32'h4080_0000, 1'b1);
    pin(32'h3F00_0000, 2'd3, 32'h0000_0000, 1'b1);
    pin(32'h3FFF_FFFF, 2'd1, 32'h4000_0000, 1'b1);
    pin(32'h4B80_0000, 2'd0, 32'h4B80_0000, 1'b0);
    pin(32'h7FA0_0000, 2'd0, 32'h7FE0_0000, 1'b0);
    pin(32'h8000_0001, 2'd0, 32'h8000_0000, 1'b0);
    pin(32'hBE99_999A, 2'd1, 32'h8000_0000, 1'b1);
    pin(32'hBF40_0000, 2'd3, 32'hBF80_0000, 1'b1);

    // Reset with junk on the inputs; they must be ignored.
    in_valid = 1'b1;
    x        = 32'h4020_0000;
    repeat (4) step();
    in_valid = 1'b0;
    rstn     = 1'b1;
    out_ready = 1'b1;
    step();

    // Directed vectors, out_ready held high.
    for (int i = 0; i < 14; i++) send(dir_x[i], dir_m[i]);
    drain();

    // Back-pressure: 8 operands, out_ready low on stream cycles 3..5.
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op(), 2'($urandom_range(0, 3)));
      end
      begin
        repeat (2) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream with 3 operands in flight.
    send(32'h4020_0000, 2'd3);
    send(32'h3FFF_FFFF, 2'd1);
    send(32'hC020_0000, 2'd0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    send(32'h4060_0000, 2'd3);
    drain();

    // Random sweep with random back-pressure and bubbles.
    rnd_rdy = 1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 7) == 0) step();
      send(rand_op(), 2'($urandom_range(0, 3)));
    end
    rnd_rdy   = 0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
